regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port flush, input, 1 bit: synchronous discard of all buffered, not-yet-issued requests.
REQ-004 SHALL have port a_valid, input, 1 bit: requester A (ALU writeback) offers a write.
REQ-005 SHALL have port a_reg, input, 5 bits: destination register of A.
REQ-006 SHALL have port a_data, input, 32 bits: write data of A.
REQ-007 SHALL have port a_ready, output, 1 bit: A's holding buffer can accept.
REQ-008 SHALL have ports b_valid, b_reg, b_data and b_ready for requester B (load writeback), with the same widths and meanings as the A ports.
REQ-009 SHALL have port write_enable, output, 1 bit: registered write strobe to the register file.
REQ-010 SHALL have port write_reg, output, 5 bits: registered write address.
REQ-011 SHALL have port write_data, output, 32 bits: registered write data.
REQ-012 SHALL have port busy, output, 32 bits: scoreboard of registers with a write in flight.

Function
REQ-013 Each requester SHALL own a one-entry holding buffer with states EMPTY and FULL.
REQ-014 x_ready SHALL equal (buffer x EMPTY) OR (buffer x granted this cycle), so one write per cycle per requester is sustained.
REQ-015 Acceptance SHALL occur at a rising edge with x_valid=1 and x_ready=1; x_reg and x_data are captured and the buffer goes FULL.
REQ-016 Requests with x_reg=0 SHALL be accepted (ready as above) but discarded: buffer stays/returns EMPTY, and no write is ever issued.
REQ-017 Each cycle, at most one FULL buffer SHALL be granted, combinationally.
REQ-018 If only one buffer is FULL, it SHALL be granted.
REQ-019 If both buffers are FULL, the grant SHALL go to the requester not granted most recently (round-robin via a 1-bit last_grant register).
REQ-020 After reset, last_grant SHALL be B, so A wins the first tie.
REQ-021 A granted buffer SHALL load its reg/data into the output registers at the next edge with write_enable=1, and go EMPTY unless refilled at that same edge (REQ-014).
REQ-022 With no grant, write_enable SHALL be 0 at the next edge; write_reg and write_data SHALL hold their values.
REQ-023 Latency SHALL be: accepted at edge N -> write_enable=1 after edge N+1 (if granted) -> register file updated at edge N+2.
REQ-024 A request losing arbitration SHALL wait at most one extra cycle.
REQ-025 busy[r] SHALL be 1 when buffer A or B is FULL with reg r, or when write_enable=1 with write_reg=r; busy[0] SHALL always be 0.
REQ-026 busy SHALL be combinational from state only, never from inputs.
REQ-027 Same-register writes SHALL follow arbitration order only; upstream stalls on busy to preserve program order.
REQ-028 flush=1 SHALL empty both buffers at the edge, and no acceptance SHALL occur that cycle; the output stage SHALL complete normally, and last_grant SHALL be unchanged.
REQ-029 flush SHALL take precedence over simultaneous grant and acceptance.

Reset
REQ-030 areset_n=0 SHALL, immediately and independent of clk, empty both buffers, set write_enable=0, write_reg=0, write_data=0, last_grant=B, and drive busy to 0.
REQ-031 a_ready and b_ready SHALL be 1 throughout reset.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight writes, with no partial write issued.

Verification
REQ-033 Single A write: A (reg 5, data 0xDEADBEEF) accepted at edge 1 -> write_enable=1, write_reg=5, write_data=0xDEADBEEF after edge 2; busy[5]=1 from edge 1 until edge 3.
REQ-034 Tie: A (reg 3, 0x11) and B (reg 4, 0x22) accepted at the same edge after reset -> reg 3 issued first, reg 4 next cycle; a second tie is then won by B.
REQ-035 Zero register: A writes reg 0 with 0xFFFFFFFF -> write_enable never asserts and busy stays 0.
REQ-036 Back-to-back: A valid every cycle with B idle -> a_ready stays 1 and one write issues per cycle in order.
REQ-037 Flush: both buffers FULL and flush=1 -> both EMPTY next cycle; the in-progress output write still asserts once.
REQ-038 Reset mid-operation: areset_n low while both buffers are FULL -> write_enable=0 and busy=0 immediately, and no write is issued after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks into a single register-file write port.
// Each source has a one-entry holding buffer; ties are broken round-robin.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// BUF_EMPTY  | holding buffer has no pending write, requester may fill it
// BUF_FULL   | holding buffer holds a write waiting for (or winning) grant
// GRANT_A    | last_grant: A won most recently, B wins the next tie
// GRANT_B    | last_grant: B won most recently (reset), A wins the next tie
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        flush,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] busy
);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;
    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    buf_state_t  a_state, a_state_nx;
    buf_state_t  b_state, b_state_nx;
    grant_t      last_grant, last_grant_nx;

    logic [4:0]  a_reg_q, a_reg_nx;
    logic [31:0] a_data_q, a_data_nx;
    logic [4:0]  b_reg_q, b_reg_nx;
    logic [31:0] b_data_q, b_data_nx;

    logic        write_enable_nx;
    logic [4:0]  write_reg_nx;
    logic [31:0] write_data_nx;

    logic        a_full, b_full;
    logic        grant_a, grant_b;
    logic        accept_a, accept_b;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            a_state      <= BUF_EMPTY;
            b_state      <= BUF_EMPTY;
            last_grant   <= GRANT_B;
            a_reg_q      <= '0;
            a_data_q     <= '0;
            b_reg_q      <= '0;
            b_data_q     <= '0;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            a_state      <= a_state_nx;
            b_state      <= b_state_nx;
            last_grant   <= last_grant_nx;
            a_reg_q      <= a_reg_nx;
            a_data_q     <= a_data_nx;
            b_reg_q      <= b_reg_nx;
            b_data_q     <= b_data_nx;
            write_enable <= write_enable_nx;
            write_reg    <= write_reg_nx;
            write_data   <= write_data_nx;
        end
    end

    // Grant depends on buffer state only; flush gates its effect, not the grant itself.
    always_comb begin
        a_full   = (a_state == BUF_FULL);
        b_full   = (b_state == BUF_FULL);
        grant_a  = a_full && (!b_full || (last_grant == GRANT_B));
        grant_b  = b_full && (!a_full || (last_grant == GRANT_A));
        a_ready  = !a_full || grant_a;
        b_ready  = !b_full || grant_b;
        accept_a = a_valid && a_ready && !flush;
        accept_b = b_valid && b_ready && !flush;
    end

    always_comb begin
        a_state_nx      = a_state;
        b_state_nx      = b_state;
        last_grant_nx   = last_grant;
        a_reg_nx        = a_reg_q;
        a_data_nx       = a_data_q;
        b_reg_nx        = b_reg_q;
        b_data_nx       = b_data_q;
        write_enable_nx = 1'b0;
        write_reg_nx    = write_reg;
        write_data_nx   = write_data;

        if (flush) begin
            a_state_nx = BUF_EMPTY;
            b_state_nx = BUF_EMPTY;
        end else begin
            if (grant_a) begin
                a_state_nx      = BUF_EMPTY;
                write_enable_nx = 1'b1;
                write_reg_nx    = a_reg_q;
                write_data_nx   = a_data_q;
                last_grant_nx   = GRANT_A;
            end else if (grant_b) begin
                b_state_nx      = BUF_EMPTY;
                write_enable_nx = 1'b1;
                write_reg_nx    = b_reg_q;
                write_data_nx   = b_data_q;
                last_grant_nx   = GRANT_B;
            end

            // Writes to r0 are swallowed: accepted, never buffered.
            if (accept_a && (a_reg != 5'd0)) begin
                a_state_nx = BUF_FULL;
                a_reg_nx   = a_reg;
                a_data_nx  = a_data;
            end
            if (accept_b && (b_reg != 5'd0)) begin
                b_state_nx = BUF_FULL;
                b_reg_nx   = b_reg;
                b_data_nx  = b_data;
            end
        end
    end

    always_comb begin
        busy = '0;
        if (a_full) begin
            busy[a_reg_q] = 1'b1;
        end
        if (b_full) begin
            busy[b_reg_q] = 1'b1;
        end
        if (write_enable) begin
            busy[write_reg] = 1'b1;
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a transaction-level model checked
// every cycle, plus hand-computed expectations for the named scenarios.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        flush = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_reg = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_reg = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fail = 0;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .flush        (flush),
        .a_valid      (a_valid),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: each requester holds at most one pending write; m_prefer_a says
    // who should win a tie (the one that did not win last).
    logic        m_a_full, m_b_full, m_prefer_a;
    logic [4:0]  m_a_reg, m_b_reg, m_wreg;
    logic [31:0] m_a_data, m_b_data, m_wdata;
    logic        m_we;
    logic        m_win_a, m_win_b, m_a_rdy, m_b_rdy;

    assign m_win_a = m_a_full && (!m_b_full || m_prefer_a);
    assign m_win_b = m_b_full && !m_win_a;
    assign m_a_rdy = !(m_a_full && !m_win_a);
    assign m_b_rdy = !(m_b_full && !m_win_b);

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            m_a_full   <= 1'b0;
            m_b_full   <= 1'b0;
            m_prefer_a <= 1'b1;
            m_a_reg    <= '0;
            m_b_reg    <= '0;
            m_a_data   <= '0;
            m_b_data   <= '0;
            m_we       <= 1'b0;
            m_wreg     <= '0;
            m_wdata    <= '0;
        end else if (flush) begin
            m_a_full <= 1'b0;
            m_b_full <= 1'b0;
            m_we     <= 1'b0;
        end else begin
            m_we <= m_win_a || m_win_b;
            if (m_win_a) begin
                m_wreg     <= m_a_reg;
                m_wdata    <= m_a_data;
                m_prefer_a <= 1'b0;
            end else if (m_win_b) begin
                m_wreg     <= m_b_reg;
                m_wdata    <= m_b_data;
                m_prefer_a <= 1'b1;
            end
            if (a_valid && m_a_rdy && a_reg != 5'd0) begin
                m_a_full <= 1'b1;
                m_a_reg  <= a_reg;
                m_a_data <= a_data;
            end else if (m_a_rdy) begin
                m_a_full <= 1'b0;
            end
            if (b_valid && m_b_rdy && b_reg != 5'd0) begin
                m_b_full <= 1'b1;
                m_b_reg  <= b_reg;
                m_b_data <= b_data;
            end else if (m_b_rdy) begin
                m_b_full <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) begin
            if ((m_a_full && m_a_reg == 5'(r)) || (m_b_full && m_b_reg == 5'(r)) ||
                (m_we && m_wreg == 5'(r)))
                v[r] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        @(negedge clk);
        check("model a_ready", 32'(a_ready), 32'(m_a_rdy));
        check("model b_ready", 32'(b_ready), 32'(m_b_rdy));
        check("model write_enable", 32'(write_enable), 32'(m_we));
        check("model write_reg", 32'(write_reg), 32'(m_wreg));
        check("model write_data", write_data, m_wdata);
        check("model busy", busy, model_busy());
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        a_valid = av;
        a_reg   = ar;
        a_data  = ad;
        b_valid = bv;
        b_reg   = br;
        b_data  = bd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        step();
        step();
        areset_n = 1'b1;
    endtask

    initial begin
        idle();
        step();
        check("reset a_ready", 32'(a_ready), 32'd1);
        check("reset b_ready", 32'(b_ready), 32'd1);
        check("reset write_enable", 32'(write_enable), 32'd0);
        check("reset busy", busy, 32'h0);
        step();
        areset_n = 1'b1;

        // Single A write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        step();
        check("single busy e1", busy, 32'h0000_0020);
        check("single we e1", 32'(write_enable), 32'd0);
        idle();
        step();
        check("single we e2", 32'(write_enable), 32'd1);
        check("single reg e2", 32'(write_reg), 32'd5);
        check("single data e2", write_data, 32'hDEADBEEF);
        check("single busy e2", busy, 32'h0000_0020);
        step();
        check("single we e3", 32'(write_enable), 32'd0);
        check("single busy e3", busy, 32'h0);

        // Tie after reset, then a second tie against the still-waiting B
        do_reset();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        step();
        check("tie busy", busy, 32'h0000_0018);
        drive(1'b1, 5'd6, 32'h33, 1'b0, 5'd0, 32'h0);
        check("tie a_ready", 32'(a_ready), 32'd1);
        check("tie b_ready", 32'(b_ready), 32'd0);
        step();
        check("tie first reg", 32'(write_reg), 32'd3);
        check("tie first data", write_data, 32'h11);
        idle();
        step();
        check("tie second reg", 32'(write_reg), 32'd4);
        check("tie second data", write_data, 32'h22);
        step();
        check("tie third reg", 32'(write_reg), 32'd6);
        check("tie third we", 32'(write_enable), 32'd1);
        step();
        check("tie drained we", 32'(write_enable), 32'd0);

        // Writes to r0 are dropped
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("zero we", 32'(write_enable), 32'd0);
            check("zero busy", busy, 32'h0);
            check("zero a_ready", 32'(a_ready), 32'd1);
        end
        idle();
        step();
        check("zero we after", 32'(write_enable), 32'd0);

        // Back-to-back A stream
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 5'(i), 32'(i * 256), 1'b0, 5'd0, 32'h0);
            step();
            check("b2b a_ready", 32'(a_ready), 32'd1);
            if (i >= 2) begin
                check("b2b we", 32'(write_enable), 32'd1);
                check("b2b reg", 32'(write_reg), 32'(i - 1));
            end
        end
        idle();
        step();
        check("b2b last reg", 32'(write_reg), 32'd6);
        check("b2b last data", write_data, 32'h600);
        step();
        check("b2b drained we", 32'(write_enable), 32'd0);

        // Flush with both buffers full and a write on the output
        do_reset();
        drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h90);
        step();
        drive(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'h0);
        step();
        check("flush prior we", 32'(write_enable), 32'd1);
        check("flush prior reg", 32'(write_reg), 32'd8);
        check("flush prior busy", busy, 32'h0000_0700);
        flush = 1'b1;
        drive(1'b1, 5'd11, 32'hB0, 1'b0, 5'd0, 32'h0);
        step();
        check("flush we", 32'(write_enable), 32'd0);
        check("flush busy", busy, 32'h0);
        flush = 1'b0;
        idle();
        step();
        check("flush no late write", 32'(write_enable), 32'd0);
        drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC1);
        step();
        idle();
        step();
        check("post-flush tie reg", 32'(write_reg), 32'd12);
        step();
        check("post-flush tie next", 32'(write_reg), 32'd11);
        step();

        // Reset mid-operation
        drive(1'b1, 5'd13, 32'hD0, 1'b1, 5'd14, 32'hE0);
        step();
        drive(1'b1, 5'd15, 32'hF0, 1'b0, 5'd0, 32'h0);
        step();
        check("midrst prior we", 32'(write_enable), 32'd1);
        idle();
        #1 areset_n = 1'b0;
        #1;
        check("midrst we", 32'(write_enable), 32'd0);
        check("midrst busy", busy, 32'h0);
        check("midrst reg", 32'(write_reg), 32'd0);
        check("midrst data", write_data, 32'h0);
        check("midrst a_ready", 32'(a_ready), 32'd1);
        check("midrst b_ready", 32'(b_ready), 32'd1);
        step();
        step();
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst release we", 32'(write_enable), 32'd0);
            check("midrst release busy", busy, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
